// File: rtl/instruction_fetch_stage.sv
// PC register and IF/ID pipeline register of the MIPS fetch stage, with stall, redirect and flush.
// Optional performance counters are enabled by defining IF_PERF_COUNTERS_EN.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid
`ifdef IF_PERF_COUNTERS_EN
    ,
    output logic [31:0] perf_fetch_count,
    output logic [31:0] perf_bubble_count
`endif
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        unused_target_lsbs;

    assign imem_address       = pc;
    assign pc_plus4           = pc + 32'd4;
    assign unused_target_lsbs = ^redirect_target[1:0];

    // Stage boundary: PC register and IF/ID register; redirect outranks stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC_ALIGNED;
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
        end else if (redirect) begin
            pc             <= {redirect_target[31:2], 2'b00};
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
        end else if (!stall) begin
            pc             <= pc_plus4;
            if_id_instr    <= imem_instr;
            if_id_pc_plus4 <= pc_plus4;
            if_id_valid    <= 1'b1;
        end
    end

`ifdef IF_PERF_COUNTERS_EN
    // Bubbles are every edge that does not deliver a new fetched word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_count  <= 32'd0;
            perf_bubble_count <= 32'd0;
        end else if (redirect || stall) begin
            perf_bubble_count <= perf_bubble_count + 32'd1;
        end else begin
            perf_fetch_count  <= perf_fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a combinational instruction memory model.
// Counter checks are included when IF_PERF_COUNTERS_EN is defined.
module tb_instruction_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] imem_address;
    logic [31:0] imem_instr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] perf_fetch_count;
    logic [31:0] perf_bubble_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    instruction_fetch_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_address    (imem_address),
        .imem_instr      (imem_instr),
        .if_id_instr     (if_id_instr),
        .if_id_pc_plus4  (if_id_pc_plus4),
        .if_id_valid     (if_id_valid)
`ifdef IF_PERF_COUNTERS_EN
        ,
        .perf_fetch_count  (perf_fetch_count),
        .perf_bubble_count (perf_bubble_count)
`endif
    );

    // Memory model: address 0 holds addi $t0,$0,5; everything else is address ^ 0xDEAD0000
    assign imem_instr = (imem_address == 32'd0) ? 32'h2008_0005 : (imem_address ^ 32'hDEAD_0000);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_if(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid);
        check_eq({tag, ".addr"},  imem_address, addr);
        check_eq({tag, ".instr"}, if_id_instr, instr);
        check_eq({tag, ".pc4"},   if_id_pc_plus4, pc4);
        check_eq({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    endtask

    initial begin
        rst_n           = 1'b0;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_target = 32'd0;

        // Power-on reset, no edge needed
        #3;
        check_if("por", 32'h0, 32'h0, 32'h0, 1'b0);
        #9 rst_n = 1'b1;

        step();
        step();
        step();
        check_eq("pre_reset.addr", imem_address, 32'hC);

        // Mid-cycle asynchronous reset
        #2 rst_n = 1'b0;
        #1;
        check_if("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
        #2 rst_n = 1'b1;
        check_eq("after_rel.addr", imem_address, 32'h0);

        // Sequential fetch
        step(); check_if("seq1", 32'h4,  32'h2008_0005, 32'h4,  1'b1);
        step(); check_if("seq2", 32'h8,  32'hDEAD_0004, 32'h8,  1'b1);
        step(); check_if("seq3", 32'hC,  32'hDEAD_0008, 32'hC,  1'b1);
        step(); check_if("seq4", 32'h10, 32'hDEAD_000C, 32'h10, 1'b1);

        // Stall holds everything
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_if("stall", 32'h10, 32'hDEAD_000C, 32'h10, 1'b1);
        end
        stall = 1'b0;
        step(); check_if("unstall", 32'h14, 32'hDEAD_0010, 32'h14, 1'b1);

        // Redirect wins over stall; low target bits dropped
        stall           = 1'b1;
        redirect        = 1'b1;
        redirect_target = 32'h0000_0103;
        step(); check_if("redir_stall", 32'h100, 32'h0, 32'h0, 1'b0);
        stall    = 1'b0;
        redirect = 1'b0;
        step(); check_if("redir_fetch", 32'h104, 32'hDEAD_0100, 32'h104, 1'b1);

        // Back-to-back redirects, then stall on a bubble
        redirect        = 1'b1;
        redirect_target = 32'h0000_0200;
        step(); check_if("redir_a", 32'h200, 32'h0, 32'h0, 1'b0);
        redirect_target = 32'h0000_0302;
        step(); check_if("redir_b", 32'h300, 32'h0, 32'h0, 1'b0);
        redirect = 1'b0;
        stall    = 1'b1;
        step(); check_if("bubble_hold", 32'h300, 32'h0, 32'h0, 1'b0);
        stall = 1'b0;
        step(); check_if("bubble_go", 32'h304, 32'hDEAD_0300, 32'h304, 1'b1);

        // PC wrap at top of address space
        redirect        = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        step(); check_eq("wrap_load.addr", imem_address, 32'hFFFF_FFFC);
        redirect = 1'b0;
        step(); check_if("wrap", 32'h0, 32'h2152_FFFC, 32'h0, 1'b1);

`ifdef IF_PERF_COUNTERS_EN
        #2 rst_n = 1'b0;
        #1;
        check_eq("perf_rst.fetch",  perf_fetch_count,  32'd0);
        check_eq("perf_rst.bubble", perf_bubble_count, 32'd0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        stall = 1'b1;
        step();
        step();
        stall           = 1'b0;
        redirect        = 1'b1;
        redirect_target = 32'h0000_0040;
        step();
        redirect = 1'b0;
        check_eq("perf.fetch",  perf_fetch_count,  32'd5);
        check_eq("perf.bubble", perf_bubble_count, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check_eq("perf_clr.fetch",  perf_fetch_count,  32'd0);
        check_eq("perf_clr.bubble", perf_bubble_count, 32'd0);
        #2 rst_n = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
